// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared memory port, one transaction outstanding.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, m0 wins).
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: requester gnt is a same-cycle acknowledge of req in IDLE; the memory
  // side holds mem_req/addr/we/wdata stable until mem_gnt is sampled high, and a
  // read completes on the single cycle mem_rvalid is seen in WAIT.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        owner_q;
  logic [7:0]  wait_cnt;
  logic        grant, win_m1, timeout_hit, rsp, err;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prefer_m1;
  assign win_m1 = m1_req & (~m0_req | prefer_m1);
`else
  assign win_m1 = m1_req & ~m0_req;
`endif

  // Gated by reset so every output is quiet while reset is held.
  assign grant       = (state == IDLE) & (m0_req | m1_req) & ~reset;
  assign timeout_hit = (wait_cnt == TIMEOUT_CNT);
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (mem_gnt) state_nxt = we_q ? IDLE : WAIT;
      WAIT:    if (mem_rvalid || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_gnt    = grant & ~win_m1;
    m1_gnt    = grant & win_m1;
    rsp       = (state == WAIT) & mem_rvalid;
    err       = (state == WAIT) & ~mem_rvalid & timeout_hit;
    m0_rvalid = rsp & ~owner_q;
    m1_rvalid = rsp & owner_q;
    m0_err    = err & ~owner_q;
    m1_err    = err & owner_q;
    m0_rdata  = m0_rvalid ? mem_rdata : 32'd0;
    m1_rdata  = m1_rvalid ? mem_rdata : 32'd0;
    mem_req   = (state == ISSUE);
    mem_addr  = mem_req ? addr_q : 32'd0;
    mem_we    = mem_req & we_q;
    mem_wdata = mem_req ? wdata_q : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      wait_cnt <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prefer_m1 <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (grant) begin
        addr_q  <= win_m1 ? m1_addr : m0_addr;
        we_q    <= win_m1 & m1_we;
        wdata_q <= win_m1 ? m1_wdata : 32'd0;
        owner_q <= win_m1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prefer_m1 <= ~win_m1;
`endif
      end
      if (state == ISSUE && mem_gnt) wait_cnt <= 8'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before an error (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_req (in, 1), m0_addr (in, 32), m0_gnt (out, 1), m0_rvalid (out, 1), m0_rdata (out, 32), m0_err (out, 1) for requester 0, the read-only instruction fetch.
REQ-005 SHALL have ports m1_req (in, 1), m1_addr (in, 32), m1_we (in, 1), m1_wdata (in, 32), m1_gnt (out, 1), m1_rvalid (out, 1), m1_rdata (out, 32), m1_err (out, 1) for requester 1, the data/debug port.
REQ-006 SHALL have ports mem_req (out, 1), mem_addr (out, 32), mem_we (out, 1), mem_wdata (out, 32), mem_gnt (in, 1), mem_rvalid (in, 1), mem_rdata (in, 32) toward the single shared memory port.

Function
REQ-007 SHALL implement an FSM with states IDLE, ISSUE and WAIT, holding at most one transaction outstanding.
REQ-008 In IDLE with any mX_req high, SHALL select one winner and assert that requester's mX_gnt combinationally in the same cycle; the losing gnt stays 0.
REQ-009 On the edge where gnt is high, SHALL capture addr, we (forced 0 for m0) and wdata into internal registers, record the owner ID, and go to ISSUE.
REQ-010 SHALL assert mX_gnt only in IDLE; a requester drops req after gnt or holds it to request again.
REQ-011 In ISSUE, SHALL drive mem_req=1 with the captured address, we and wdata held stable until mem_gnt is sampled high.
REQ-012 On ISSUE with mem_gnt=1 and captured we=1, SHALL return to IDLE with no rvalid; with we=0, SHALL go to WAIT.
REQ-013 In WAIT, SHALL drive mem_req=0 and, when mem_rvalid=1, assert the owner's rvalid for exactly that cycle with rdata=mem_rdata (combinational pass-through), then return to IDLE.
REQ-014 SHALL ignore mem_rvalid in IDLE and ISSUE; the non-owner's rvalid SHALL stay 0 at all times.
REQ-015 mX_rdata SHALL be 0 whenever mX_rvalid=0.
REQ-016 A WAIT cycle counter (8 bits, cleared on WAIT entry) reaching TIMEOUT without mem_rvalid SHALL pulse the owner's mX_err for one cycle and return to IDLE; an rvalid arriving in that same cycle takes precedence, with no err.
REQ-017 mem_addr, mem_we and mem_wdata SHALL be 0 outside ISSUE.
REQ-018 Minimum read latency SHALL be 3 cycles from gnt to rvalid (gnt, ISSUE with mem_gnt, WAIT with rvalid); a write SHALL occupy 2 cycles.

Reset
REQ-019 Asserting reset at any time SHALL immediately force IDLE, clear the captured registers, the owner ID, the timeout counter and the priority pointer, and drive every output to 0.
REQ-020 A response for a transaction aborted by reset SHALL be discarded, with no rvalid or err.
REQ-021 The first arbitration after reset SHALL favour m0.

Configuration
REQ-022 With macro MEM_ARB_ROUND_ROBIN_EN defined, SHALL arbitrate round-robin: on simultaneous requests, the requester that did not win last wins, and the pointer updates only on a grant.
REQ-023 Without MEM_ARB_ROUND_ROBIN_EN, SHALL use fixed priority with m0 always winning simultaneous requests.

Verification
REQ-024 Scenario: m0 read at 0x0000_0100, mem_gnt immediate, mem_rvalid 1 cycle later with 0xDEAD_BEEF -> m0_gnt at cycle 0, mem_req at cycle 1, m0_rvalid with 0xDEAD_BEEF at cycle 2, m1 outputs 0.
REQ-025 Scenario: m1 write at 0x0000_2000 with data 0x1234_5678, mem_gnt stalled 3 cycles -> mem_req/addr/wdata/we held for 4 cycles, no m1_rvalid, IDLE next cycle.
REQ-026 Scenario: m0 and m1 request continuously for 4 grants -> with MEM_ARB_ROUND_ROBIN_EN grants go m0, m1, m0, m1; without it grants go m0, m0, m0, m0.
REQ-027 Scenario: m1 read, mem_rvalid never asserted, TIMEOUT=16 -> m1_err pulses exactly 16 WAIT cycles after entry, then m0 is grantable.
REQ-028 Scenario: reset pulsed during WAIT, then mem_rvalid=1 with 0xCAFE_0000 -> no rvalid on either port, all outputs 0, next m0 request granted normally.
